chacha_keystream_gen: RTL and testbench

//  Multi-block ChaCha keystream generator with a configurable round count; successor to the single-block ChaCha block function.

---
 rtl/chacha_pkg.sv | 41 ++++
 rtl/chacha_double_round.sv | 22 ++
 rtl/chacha_keystream_gen.sv | 189 ++++++++++++++++++
 tb/tb_chacha_keystream_gen.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared ChaCha word/state types, sigma constants, FSM encoding and the
// quarter-round, byte-swap and serialization helpers.
package chacha_pkg;
  typedef logic [31:0] word_t;
  typedef word_t state_t [16];

  localparam word_t SIGMA0 = 32'h6170_7865;
  localparam word_t SIGMA1 = 32'h3320_646e;
  localparam word_t SIGMA2 = 32'h7962_2d32;
  localparam word_t SIGMA3 = 32'h6b20_6574;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_OUT   = 2'd2
  } ks_state_e;

  // Converts between a big-endian byte stream slice and a little-endian word.
  function automatic word_t bswap(input word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [127:0] qr(input word_t a_in, input word_t b_in,
                                      input word_t c_in, input word_t d_in);
    word_t a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Word 0 low byte lands in the top byte of the block.
  function automatic logic [511:0] serialize(input state_t s);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = bswap(s[i]);
    return r;
  endfunction
endpackage

// File: rtl/chacha_double_round.sv
// Combinational ChaCha double round: four column quarter-rounds followed by
// four diagonal quarter-rounds.
module chacha_double_round
  import chacha_pkg::*;
(
  input  state_t i_state,
  output state_t o_state
);
  state_t w_s;

  always_comb begin
    w_s = i_state;
    for (int i = 0; i < 4; i++)
      {w_s[i], w_s[4+i], w_s[8+i], w_s[12+i]} =
        qr(w_s[i], w_s[4+i], w_s[8+i], w_s[12+i]);
    // Diagonal i touches (i, 4+(i+1)%4, 8+(i+2)%4, 12+(i+3)%4).
    for (int i = 0; i < 4; i++)
      {w_s[i], w_s[4+((i+1)%4)], w_s[8+((i+2)%4)], w_s[12+((i+3)%4)]} =
        qr(w_s[i], w_s[4+((i+1)%4)], w_s[8+((i+2)%4)], w_s[12+((i+3)%4)]);
    o_state = w_s;
  end
endmodule

// File: rtl/chacha_keystream_gen.sv
// Multi-block ChaCha keystream generator, one double round per cycle, with
// valid/ready output. Optional abort input enabled by CHACHA_KS_ABORT_EN.
module chacha_keystream_gen
  import chacha_pkg::*;
#(
  parameter int KEY_WIDTH         = 256,
  parameter int NONCE_WIDTH       = 96,
  parameter int BLOCK_COUNT_WIDTH = 32,
  parameter int NBLK_WIDTH        = 16,
  parameter int ROUNDS            = 20,
  parameter int OUT_WIDTH         = 512
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [KEY_WIDTH-1:0]         key,
  input  logic [NONCE_WIDTH-1:0]       nonce,
  input  logic [BLOCK_COUNT_WIDTH-1:0] block_count,
  input  logic [NBLK_WIDTH-1:0]        num_blocks,
  input  logic                         start,
  output logic                         ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out,
  output logic                         out_last,
  output logic                         done,
  output logic                         ctr_wrap_err,
`ifdef CHACHA_KS_ABORT_EN
  input  logic                         abort,
`endif
  output logic [1:0]                   dbg_state
);
  // Output handshake: a block transfers on a rising clk edge where
  // out_valid && out_ready; out/out_last hold while out_valid && !out_ready.
  if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
    $error("chacha_keystream_gen: ROUNDS must be 8, 12 or 20");
  end

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS / 2);

  ks_state_e             r_state, w_next_state;
  state_t                r_init, r_work, w_init, w_dr_out, w_sum;
  logic [OUT_WIDTH-1:0]  r_out;
  logic                  r_out_valid, r_out_last, r_done, r_wrap_err;
  logic [3:0]            r_round;
  logic [NBLK_WIDTH-1:0] r_blocks_left;
  logic                  w_abort_in, w_load, w_zero_req, w_step, w_emit;
  logic                  w_advance, w_finish, w_abort, w_ctr_max, w_one_left;
  word_t                 w_next_ctr;

`ifdef CHACHA_KS_ABORT_EN
  assign w_abort_in = abort;
`else
  assign w_abort_in = 1'b0;
`endif

  chacha_double_round u_dr (.i_state(r_work), .o_state(w_dr_out));

  always_comb begin
    w_init[0] = SIGMA0;
    w_init[1] = SIGMA1;
    w_init[2] = SIGMA2;
    w_init[3] = SIGMA3;
    for (int j = 0; j < 8; j++) w_init[4+j] = bswap(key[KEY_WIDTH-1-32*j -: 32]);
    w_init[12] = block_count;
    for (int j = 0; j < 3; j++) w_init[13+j] = bswap(nonce[NONCE_WIDTH-1-32*j -: 32]);
    for (int j = 0; j < 16; j++) w_sum[j] = r_work[j] + r_init[j];
  end

  assign w_ctr_max  = (r_init[12] == 32'hFFFF_FFFF);
  assign w_one_left = (r_blocks_left == NBLK_WIDTH'(1));
  assign w_next_ctr = r_init[12] + 32'd1;

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_zero_req   = 1'b0;
    w_step       = 1'b0;
    w_emit       = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (num_blocks != '0) begin
            w_load       = 1'b1;
            w_next_state = ST_ROUND;
          end else begin
            w_zero_req = 1'b1;
          end
        end
      end
      ST_ROUND: begin
        if (w_abort_in) begin
          w_abort      = 1'b1;
          w_next_state = ST_IDLE;
        end else if (r_round == LAST_ROUND) begin
          w_emit       = 1'b1;
          w_next_state = ST_OUT;
        end else begin
          w_step = 1'b1;
        end
      end
      ST_OUT: begin
        if (w_abort_in) begin
          w_abort      = 1'b1;
          w_next_state = ST_IDLE;
        end else if (r_out_valid && out_ready) begin
          if (r_out_last) begin
            w_finish     = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_advance    = 1'b1;
            w_next_state = ST_ROUND;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_init        <= '{default: '0};
      r_work        <= '{default: '0};
      r_out         <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_done        <= 1'b0;
      r_wrap_err    <= 1'b0;
      r_round       <= '0;
      r_blocks_left <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_init        <= w_init;
        r_work        <= w_init;
        r_round       <= '0;
        r_blocks_left <= num_blocks;
        r_wrap_err    <= 1'b0;
      end
      if (w_zero_req) begin
        r_done     <= 1'b1;
        r_wrap_err <= 1'b0;
      end
      if (w_step) begin
        r_work  <= w_dr_out;
        r_round <= r_round + 4'd1;
      end
      if (w_emit) begin
        r_out       <= serialize(w_sum);
        r_out_valid <= 1'b1;
        // A counter at its maximum cannot advance, so the request ends here.
        r_out_last  <= w_one_left || w_ctr_max;
        r_wrap_err  <= r_wrap_err || (w_ctr_max && !w_one_left);
      end
      if (w_advance) begin
        r_init[12]    <= w_next_ctr;
        r_work        <= r_init;
        r_work[12]    <= w_next_ctr;
        r_round       <= '0;
        r_blocks_left <= r_blocks_left - NBLK_WIDTH'(1);
        r_out_valid   <= 1'b0;
      end
      if (w_finish) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_done      <= 1'b1;
      end
      if (w_abort) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign ready        = (r_state == ST_IDLE);
  assign out_valid    = r_out_valid;
  assign out          = r_out;
  assign out_last     = r_out_last;
  assign done         = r_done;
  assign ctr_wrap_err = r_wrap_err;
  assign dbg_state    = r_state;
endmodule

// File: tb/tb_chacha_keystream_gen.sv
// Scoreboard bench for chacha_keystream_gen against a per-round ChaCha model;
// also runs ROUNDS=8 and ROUNDS=12 instances and the CHACHA_KS_ABORT_EN path.
module tb_chacha_keystream_gen;
  localparam int W = 513;
  localparam logic [255:0] RFC_KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0]  RFC_NONCE = 96'h000000090000004a00000000;
  localparam int QI [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                               '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  block_count;
  logic [15:0]  num_blocks;
  logic         start, out_ready, one, abort;
  logic         ready, out_valid, out_last, done, ctr_wrap_err;
  logic [511:0] out;
  logic [1:0]   dbg_state;
  logic         start8, ready8, valid8, last8, done8, werr8;
  logic         start12, ready12, valid12, last12, done12, werr12;
  logic [511:0] out8, out12;
  logic [1:0]   dbg8, dbg12;

  chacha_keystream_gen dut (
    .clk(clk), .reset(reset), .key(key), .nonce(nonce), .block_count(block_count),
    .num_blocks(num_blocks), .start(start), .ready(ready), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .out_last(out_last), .done(done),
    .ctr_wrap_err(ctr_wrap_err),
`ifdef CHACHA_KS_ABORT_EN
    .abort(abort),
`endif
    .dbg_state(dbg_state));

  chacha_keystream_gen #(.ROUNDS(8)) dut8 (
    .clk(clk), .reset(reset), .key(key), .nonce(nonce), .block_count(block_count),
    .num_blocks(num_blocks), .start(start8), .ready(ready8), .out_valid(valid8),
    .out_ready(one), .out(out8), .out_last(last8), .done(done8),
    .ctr_wrap_err(werr8),
`ifdef CHACHA_KS_ABORT_EN
    .abort(abort),
`endif
    .dbg_state(dbg8));

  chacha_keystream_gen #(.ROUNDS(12)) dut12 (
    .clk(clk), .reset(reset), .key(key), .nonce(nonce), .block_count(block_count),
    .num_blocks(num_blocks), .start(start12), .ready(ready12), .out_valid(valid12),
    .out_ready(one), .out(out12), .out_last(last12), .done(done12),
    .ctr_wrap_err(werr12),
`ifdef CHACHA_KS_ABORT_EN
    .abort(abort),
`endif
    .dbg_state(dbg12));

  logic [W-1:0] exp_q[$];
  int n_checks = 0, n_fail = 0, exp_done = 0, done_seen = 0;
  bit rand_rdy = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] le32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int nb);
    return (v << nb) | (v >> (32 - nb));
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c, input int rounds);
    logic [127:0] sig;
    logic [31:0]  s[16], x[16];
    logic [511:0] r;
    int a, b, cc, d;
    sig = "expand 32-byte k";
    for (int i = 0; i < 4; i++) s[i] = le32(sig[127-32*i -: 32]);
    for (int i = 0; i < 8; i++) s[4+i] = le32(k[255-32*i -: 32]);
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = le32(n[95-32*i -: 32]);
    x = s;
    for (int rd = 0; rd < rounds; rd++) begin
      for (int j = 0; j < 4; j++) begin
        a = QI[(rd%2)*4+j][0]; b = QI[(rd%2)*4+j][1];
        cc = QI[(rd%2)*4+j][2]; d = QI[(rd%2)*4+j][3];
        x[a] = x[a] + x[b];   x[d] = rotl(x[d] ^ x[a], 16);
        x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 12);
        x[a] = x[a] + x[b];   x[d] = rotl(x[d] ^ x[a], 8);
        x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = le32(x[i] + s[i]);
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [255:0] k, input logic [95:0] n,
                       input logic [31:0] c, input logic [15:0] nb);
    logic [31:0] cb;
    logic        last;
    key = k; nonce = n; block_count = c; num_blocks = nb; start = 1'b1;
    for (int b = 0; b < int'(nb); b++) begin
      cb   = c + 32'(b);
      last = (b == int'(nb) - 1) || (cb == 32'hFFFF_FFFF);
      exp_q.push_back({last, ref_block(k, n, cb, 20)});
      if (last) break;
    end
    exp_done++;
    @(posedge clk); #1;
    start = 1'b0;
    key = rand256(); nonce = {$urandom, $urandom, $urandom};
    block_count = $urandom; num_blocks = 16'($urandom);
  endtask

  task automatic wait_valid(input int max_cyc, output int lat);
    lat = 0;
    while (!out_valid && lat < max_cyc) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL wait_valid: out_valid=0 after %0d cycles, required 1", lat);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int cnt = 0;
    while (!ready && cnt < max_cyc) begin @(posedge clk); #1; cnt++; end
    if (!ready) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: ready=0 after %0d cycles, required 1", cnt);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] mon_e, stall_d;
  bit stall_v = 0, pend_done = 0;
  always @(negedge clk) begin
    if (reset) begin
      stall_v = 0; pend_done = 0;
    end else begin
      if (pend_done) begin
        check("done_with_ready", {done, ready}, 2'b11);
        pend_done = 0;
      end
      if (done) done_seen++;
      if (stall_v && out_valid) check("stall_stable", {out_last, out}, stall_d);
      stall_v = out_valid && !out_ready;
      stall_d = {out_last, out};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_block", {out_last, out}, '0);
        else begin
          mon_e = exp_q.pop_front();
          check("block", {out_last, out}, mon_e);
          if (mon_e[512]) pend_done = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int lat;
  logic [255:0] sk;
  logic [95:0]  sn;
  logic [31:0]  sc;
  initial begin
    reset = 1'b1; start = 1'b0; start8 = 1'b0; start12 = 1'b0; one = 1'b1; abort = 1'b0;
    out_ready = 1'b0; key = '0; nonce = '0; block_count = '0; num_blocks = '0;
    repeat (3) @(posedge clk); #1;
    check("reset_flags", {ready, out_valid, out_last, done, ctr_wrap_err}, 5'b10000);
    check("reset_out", out, '0);
    check("reset_state", dbg_state, 2'd0);
    reset = 1'b0;

    // RFC 8439 block vector
    issue(RFC_KEY, RFC_NONCE, 32'd1, 16'd1);
    wait_valid(40, lat);
    check("t1_latency", lat, 11);
    check("t1_head", out[511:448], 64'h10f1e7e4d13b5915);
    check("t1_tail", out[63:0], 64'hcbd083e8a2503c4e);
    check("t1_last", out_last, 1'b1);
    check("t1_wrap", ctr_wrap_err, 1'b0);
    out_ready = 1'b1;
    wait_idle(100);
    out_ready = 1'b0;

    // three blocks, stall on the second
    issue(RFC_KEY, RFC_NONCE, 32'd1, 16'd3);
    wait_valid(40, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t2_valid_drop", out_valid, 1'b0);
    wait_valid(40, lat);
    check("t2_latency2", lat, 11);
    repeat (5) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_idle(100);

    // counter wrap
    issue(RFC_KEY, RFC_NONCE, 32'hFFFF_FFFE, 16'd4);
    wait_idle(200);
    check("t3_wrap_set", ctr_wrap_err, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check("t3_wrap_sticky", ctr_wrap_err, 1'b1);
    out_ready = 1'b0;

    // zero-length request, then starts while busy
    issue(rand256(), 96'h1, 32'd5, 16'd0);
    check("t4_done", {done, out_valid, ready}, 3'b101);
    check("t4_wrap_clr", ctr_wrap_err, 1'b0);
    @(posedge clk); #1;
    check("t4_done_pulse", done, 1'b0);
    issue(rand256(), {$urandom, $urandom, $urandom}, $urandom, 16'd1);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; num_blocks = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("t4_busy_round", ready, 1'b0);
    wait_valid(40, lat);
    start = 1'b1; num_blocks = 16'd2; key = rand256();
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    check("t4_busy_out", {ready, out_valid}, 2'b01);
    out_ready = 1'b1;
    wait_idle(100);
    out_ready = 1'b0;

    // ROUNDS=8 and ROUNDS=12 instances
    for (int w = 0; w < 2; w++) begin
      sk = rand256(); sn = {$urandom, $urandom, $urandom}; sc = $urandom;
      key = sk; nonce = sn; block_count = sc; num_blocks = 16'd1;
      if (w == 1) start12 = 1'b1; else start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; start12 = 1'b0;
      lat = 0;
      while (!(w == 1 ? valid12 : valid8) && lat < 40) begin @(posedge clk); #1; lat++; end
      if (w == 1) begin
        check("r12_latency", lat, 7);
        check("r12_block", {last12, out12}, {1'b1, ref_block(sk, sn, sc, 12)});
      end else begin
        check("r8_latency", lat, 5);
        check("r8_block", {last8, out8}, {1'b1, ref_block(sk, sn, sc, 8)});
      end
      repeat (2) @(posedge clk); #1;
    end

    // reset mid-ROUND and during an OUT stall
    issue(rand256(), {$urandom, $urandom, $urandom}, $urandom, 16'd2);
    repeat (6) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_rst_round", {ready, out_valid, out_last, done, ctr_wrap_err}, 5'b10000);
    exp_q.delete(); exp_done--;
    issue(rand256(), {$urandom, $urandom, $urandom}, 32'hFFFF_FFFF, 16'd3);
    wait_valid(40, lat);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_rst_out", {ready, out_valid, out_last, done, ctr_wrap_err}, 5'b10000);
    check("t6_rst_data", out, '0);
    exp_q.delete(); exp_done--;

`ifdef CHACHA_KS_ABORT_EN
    issue(rand256(), {$urandom, $urandom, $urandom}, $urandom, 16'd2);
    repeat (4) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", {ready, out_valid, done}, 3'b100);
    @(posedge clk); #1;
    check("abort_no_done", done, 1'b0);
    exp_q.delete(); exp_done--;
`endif

    // randomized requests with random backpressure
    rand_rdy = 1;
    for (int it = 0; it < 10; it++) begin
      sc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
      issue(rand256(), {$urandom, $urandom, $urandom}, sc, 16'($urandom_range(1, 3)));
      wait_idle(3000);
    end
    rand_rdy = 0;
    out_ready = 1'b0;

    repeat (3) begin @(posedge clk); #1; end
    check("queue_empty", exp_q.size(), 0);
    check("done_count", done_seen, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
